// File: rtl/ram_rr_arbiter_if.sv
// Bundle of the two requester ports and the RAM port that the arbiter sits between.
// The arbiter takes the slave view; the client side (engines plus RAM) takes the master view.
interface ram_rr_arbiter_if #(
  parameter int addressWidth = 5,
  parameter int dataWidth    = 32
);
  logic                    req0;
  logic                    we0;
  logic [addressWidth-1:0] addr0;
  logic [dataWidth-1:0]    din0;
  logic                    gnt0;
  logic                    rvalid0;
  logic [dataWidth-1:0]    rdata0;

  logic                    req1;
  logic                    we1;
  logic [addressWidth-1:0] addr1;
  logic [dataWidth-1:0]    din1;
  logic                    gnt1;
  logic                    rvalid1;
  logic [dataWidth-1:0]    rdata1;

  logic                    ram_en;
  logic                    ram_we;
  logic [addressWidth-1:0] ram_address;
  logic [dataWidth-1:0]    ram_din;
  logic [dataWidth-1:0]    ram_dout;

  modport slave (
    input  req0, we0, addr0, din0, req1, we1, addr1, din1, ram_dout,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           ram_en, ram_we, ram_address, ram_din
  );

  modport master (
    output req0, we0, addr0, din0, req1, we1, addr1, din1, ram_dout,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           ram_en, ram_we, ram_address, ram_din
  );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port write-first RAM between two requesters,
// with a bounded burst tenure and per-requester read-data return one cycle after grant.
module ram_rr_arbiter #(
  parameter int addressWidth = 5,
  parameter int dataWidth    = 32,
  parameter int maxBurst     = 4
) (
  input logic             clk,
  input logic             rst_n,
  ram_rr_arbiter_if.slave bus
);
  localparam int cnt_width = $clog2(maxBurst + 1);
  localparam logic [cnt_width-1:0] cnt_max = cnt_width'(maxBurst);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

  owner_t                  owner, owner_next;
  logic [cnt_width-1:0]    cnt, cnt_next;
  logic                    lp, lp_next;
  logic                    rp0, rp1;
  logic                    gnt0, gnt1;
  logic                    rvalid0, rvalid1;
  logic                    we_sel;
  logic [addressWidth-1:0] addr_sel;
  logic [dataWidth-1:0]    din_sel;

  // The owner keeps the port until its tenure is used up and the other side is waiting.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (owner)
        OWN0: begin
          if (bus.req0 && (cnt < cnt_max || !bus.req1)) gnt0 = 1'b1;
          else if (bus.req1)                             gnt1 = 1'b1;
        end
        OWN1: begin
          if (bus.req1 && (cnt < cnt_max || !bus.req0)) gnt1 = 1'b1;
          else if (bus.req0)                             gnt0 = 1'b1;
        end
        default: begin
          if (bus.req0 && bus.req1) begin
            gnt0 = lp;
            gnt1 = !lp;
          end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
          end
        end
      endcase
    end
  end

  always_comb begin
    owner_next = IDLE;
    cnt_next   = '0;
    lp_next    = lp;
    if (gnt0) begin
      owner_next = OWN0;
      if (owner == OWN0) begin
        cnt_next = (cnt == cnt_max) ? cnt : cnt + 1'b1;
      end else begin
        cnt_next = cnt_width'(1);
        lp_next  = 1'b0;
      end
    end else if (gnt1) begin
      owner_next = OWN1;
      if (owner == OWN1) begin
        cnt_next = (cnt == cnt_max) ? cnt : cnt + 1'b1;
      end else begin
        cnt_next = cnt_width'(1);
        lp_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner <= IDLE;
      cnt   <= '0;
      lp    <= 1'b1;
      rp0   <= 1'b0;
      rp1   <= 1'b0;
    end else begin
      owner <= owner_next;
      cnt   <= cnt_next;
      lp    <= lp_next;
      rp0   <= gnt0 && !bus.we0;
      rp1   <= gnt1 && !bus.we1;
    end
  end

  always_comb begin
    we_sel   = 1'b0;
    addr_sel = '0;
    din_sel  = '0;
    if (gnt0) begin
      we_sel   = bus.we0;
      addr_sel = bus.addr0;
      din_sel  = bus.din0;
    end else if (gnt1) begin
      we_sel   = bus.we1;
      addr_sel = bus.addr1;
      din_sel  = bus.din1;
    end
  end

  // Pending reads are suppressed while reset is held so nothing leaks out mid-reset.
  assign rvalid0 = rp0 && rst_n;
  assign rvalid1 = rp1 && rst_n;

  assign bus.gnt0        = gnt0;
  assign bus.gnt1        = gnt1;
  assign bus.rvalid0     = rvalid0;
  assign bus.rvalid1     = rvalid1;
  assign bus.rdata0      = rvalid0 ? bus.ram_dout : '0;
  assign bus.rdata1      = rvalid1 ? bus.ram_dout : '0;
  assign bus.ram_en      = gnt0 || gnt1;
  assign bus.ram_we      = we_sel;
  assign bus.ram_address = addr_sel;
  assign bus.ram_din     = din_sel;
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed plus randomized bench for ram_rr_arbiter against a behavioural arbitration
// and memory model; a write-first RAM model is attached to the RAM port.
module tb_ram_rr_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ram_rr_arbiter_if #(.addressWidth(AW), .dataWidth(DW)) bus ();

  ram_rr_arbiter #(.addressWidth(AW), .dataWidth(DW), .maxBurst(MAX_BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Write-first single-port RAM with one cycle of read latency.
  logic [DW-1:0] ram_mem [1 << AW];
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram_mem[i] = '0;
    bus.ram_dout = '0;
  end
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        ram_mem[bus.ram_address] <= bus.ram_din;
        bus.ram_dout             <= bus.ram_din;
      end else begin
        bus.ram_dout <= ram_mem[bus.ram_address];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;

  // Reference model: who owns the port, how long they have held it, who was served last.
  int            m_owner  = -1;
  int            m_streak = 0;
  int            m_last   = 1;
  bit            m_pend      [2];
  logic [DW-1:0] m_pend_data [2];
  logic [DW-1:0] m_shadow    [1 << AW];

  function automatic int pick(input bit r0, input bit r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1)  return 0;
    if (r1 && !r0)  return 1;
    if (m_owner >= 0) return (m_streak < MAX_BURST) ? m_owner : 1 - m_owner;
    return 1 - m_last;
  endfunction

  task automatic check_output(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL step%0d %s observed=%0h expected=%0h", step_no, tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input bit rn,
                                input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int            g;
    bit            w [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    @(negedge clk);
    rst_n     = rn;
    bus.req0  = r0; bus.we0 = w0; bus.addr0 = a0; bus.din0 = d0;
    bus.req1  = r1; bus.we1 = w1; bus.addr1 = a1; bus.din1 = d1;
    w[0] = w0; a[0] = a0; d[0] = d0;
    w[1] = w1; a[1] = a1; d[1] = d1;
    #1;
    g = rn ? pick(r0, r1) : -1;
    check_output("gnt0", DW'(bus.gnt0), DW'(g == 0));
    check_output("gnt1", DW'(bus.gnt1), DW'(g == 1));
    check_output("ram_en", DW'(bus.ram_en), DW'(g >= 0));
    check_output("ram_we", DW'(bus.ram_we), DW'((g >= 0) ? w[g] : 1'b0));
    check_output("ram_address", DW'(bus.ram_address), DW'((g >= 0) ? a[g] : '0));
    check_output("ram_din", bus.ram_din, (g >= 0) ? d[g] : '0);
    check_output("rvalid0", DW'(bus.rvalid0), DW'(rn && m_pend[0]));
    check_output("rvalid1", DW'(bus.rvalid1), DW'(rn && m_pend[1]));
    check_output("rdata0", bus.rdata0, (rn && m_pend[0]) ? m_pend_data[0] : '0);
    check_output("rdata1", bus.rdata1, (rn && m_pend[1]) ? m_pend_data[1] : '0);

    if (!rn) begin
      m_owner = -1; m_streak = 0; m_last = 1;
      m_pend[0] = 1'b0; m_pend[1] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_pend[k] = (g == k) && !w[k];
        if (m_pend[k]) m_pend_data[k] = m_shadow[a[k]];
      end
      if (g >= 0 && w[g]) m_shadow[a[g]] = d[g];
      if (g < 0) begin
        m_owner = -1; m_streak = 0;
      end else if (g == m_owner) begin
        m_streak = (m_streak < MAX_BURST) ? m_streak + 1 : MAX_BURST;
      end else begin
        m_owner = g; m_streak = 1; m_last = g;
      end
    end
    step_no++;
  endtask

  initial begin
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.din0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.din1 = '0;
    for (int i = 0; i < (1 << AW); i++) m_shadow[i] = '0;
    m_pend[0] = 1'b0; m_pend[1] = 1'b0;
    m_pend_data[0] = '0; m_pend_data[1] = '0;

    $display("[TB] reset, with requests held to show grants are masked");
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 5'd1, 0, 1, 0, 5'd2, 0);

    $display("[TB] requester 0 write then read of address 3");
    apply_stimulus(1, 1, 1, 5'd3, 32'hA5A5A5A5, 0, 0, 0, 0);
    apply_stimulus(1, 1, 0, 5'd3, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] requester 0 alone for 10 cycles");
    for (int i = 0; i < 10; i++)
      apply_stimulus(1, 1, i[0], AW'(i), $urandom, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] both requesters reading continuously from reset");
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++)
      apply_stimulus(1, 1, 0, AW'(i), 0, 1, 0, AW'(i + 1), 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] idle tie after requester 0 was last served");
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 0, 5'd4, 0, 1, 0, 5'd5, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 0, 5'd6, 0, 1, 0, 5'd7, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] requester 0 drops mid-burst while requester 1 waits");
    apply_stimulus(1, 1, 1, 5'd8, 32'h1111_0000, 0, 0, 0, 0);
    apply_stimulus(1, 1, 1, 5'd9, 32'h2222_0000, 1, 0, 5'd8, 0);
    apply_stimulus(1, 0, 0, 0, 0, 1, 0, 5'd8, 0);
    apply_stimulus(1, 0, 0, 0, 0, 1, 0, 5'd9, 0);

    $display("[TB] reset right after a requester 1 read is granted");
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 1, 0, 5'd8, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 5'd8, 0);
    apply_stimulus(1, 0, 0, 0, 0, 1, 0, 5'd9, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++)
      apply_stimulus($urandom_range(0, 39) != 0,
                     $urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 7)), $urandom,
                     $urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 7)), $urandom);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
